// File: rtl/riscv_core_wb_arb.sv
// riscv_core_wb_arb: merges pipeline and long-latency (M-unit) results onto the RF write port. It also keeps a pending-register busy mask.
// Latency: a pipe write appears 1 cycle after the request. An LU result takes 2 cycles through the FIFO, or 1 cycle when RISCV_WB_BYPASS_EN is defined and the FIFO is empty.
// Backpressure: the pipe is never stalled. o_wb_lu_ready is low while the LU FIFO is full or while reset is high.
module riscv_core_wb_arb #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic            i_wb_clk,
  input  logic            i_wb_rst,
  input  logic            i_wb_pipe_we,
  input  logic [4:0]      i_wb_pipe_rd,
  input  logic [XLEN-1:0] i_wb_pipe_data,
  input  logic            i_wb_lu_valid,
  input  logic [4:0]      i_wb_lu_rd,
  input  logic [XLEN-1:0] i_wb_lu_data,
  output logic            o_wb_lu_ready,
  input  logic            i_wb_issue,
  input  logic [4:0]      i_wb_issue_rd,
  output logic [31:0]     o_wb_busy,
  output logic            o_wb_rf_we,
  output logic [4:0]      o_wb_rf_a,
  output logic [XLEN-1:0] o_wb_rf_wd
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } lu_ent_t;

  lu_ent_t          fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      busy_q;
  logic [31:0]      set_mask;
  logic [31:0]      clr_mask;
  lu_ent_t          head;
  lu_ent_t          lu_in;
  logic             full;
  logic             empty;
  logic             pipe_act;
  logic             lu_xfer;
  logic             lu_keep;
  logic             bypass;
  logic             push;
  logic             pop;

  // A pipe write to x0 is a no-op, so it must not block the port.
  assign pipe_act      = i_wb_pipe_we && (i_wb_pipe_rd != 5'd0);
  assign full          = (count == CNT_W'(DEPTH));
  assign empty         = (count == '0);
  assign o_wb_lu_ready = !i_wb_rst && !full;
  assign lu_xfer       = i_wb_lu_valid && o_wb_lu_ready;
  // An LU result aimed at x0 completes the handshake but is thrown away.
  assign lu_keep       = lu_xfer && (i_wb_lu_rd != 5'd0);
  assign lu_in         = {i_wb_lu_rd, i_wb_lu_data};
  assign head          = fifo_mem[rd_ptr];

`ifdef RISCV_WB_BYPASS_EN
  // An empty FIFO with an idle port lets a fresh LU result go straight to the output register.
  assign bypass = lu_keep && empty && !pipe_act;
`else
  assign bypass = 1'b0;
`endif

  assign push = lu_keep && !bypass;
  assign pop  = !pipe_act && !empty;

  // FIFO storage. Stale entries are harmless because the pointers and the count define validity.
  always_ff @(posedge i_wb_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= lu_in;
    end
  end

  // FIFO pointers and occupancy. DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Registered RF write port. The pipe has priority, then the FIFO head, then a bypassed LU result.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      o_wb_rf_we <= 1'b0;
      o_wb_rf_a  <= 5'd0;
      o_wb_rf_wd <= '0;
    end else if (pipe_act) begin
      o_wb_rf_we <= 1'b1;
      o_wb_rf_a  <= i_wb_pipe_rd;
      o_wb_rf_wd <= i_wb_pipe_data;
    end else if (pop) begin
      o_wb_rf_we <= 1'b1;
      o_wb_rf_a  <= head.rd;
      o_wb_rf_wd <= head.data;
    end else if (bypass) begin
      o_wb_rf_we <= 1'b1;
      o_wb_rf_a  <= i_wb_lu_rd;
      o_wb_rf_wd <= i_wb_lu_data;
    end else begin
      o_wb_rf_we <= 1'b0;
    end
  end

  // Busy bit updates. A new issue sets its bit, and an LU-sourced write into the output register clears its bit.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (i_wb_issue && (i_wb_issue_rd != 5'd0)) begin
      set_mask[i_wb_issue_rd] = 1'b1;
    end
    if (pop) begin
      clr_mask[head.rd] = 1'b1;
    end else if (bypass) begin
      clr_mask[i_wb_lu_rd] = 1'b1;
    end
  end

  // Busy mask register. The set is applied after the clear, so a re-issue of the same register wins.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
    end
  end

  assign o_wb_busy = busy_q;

endmodule

// File: tb/tb_riscv_core_wb_arb.sv
// tb_riscv_core_wb_arb: directed bench for the writeback arbiter, checked against a scoreboard of expected RF writes.
// Inputs change 1ns after posedge. Direct checks run at that point, and the write monitor samples on negedge.
// Pipe and LU writes are queued separately. The pipe always wins, and LU results keep their arrival order.
module tb_riscv_core_wb_arb;

  typedef struct {
    logic [4:0]  a;
    logic [63:0] d;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [63:0] pipe_data;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [63:0] lu_data;
  logic        lu_ready;
  logic        issue;
  logic [4:0]  issue_rd;
  logic [31:0] busy;
  logic        rf_we;
  logic [4:0]  rf_a;
  logic [63:0] rf_wd;

  int  n_cmp  = 0;
  int  n_fail = 0;
  wr_t pipe_q[$];
  wr_t lu_q[$];
  logic pipe_prev = 1'b0;

  riscv_core_wb_arb #(.XLEN(64), .DEPTH(2)) dut (
    .i_wb_clk       (clk),
    .i_wb_rst       (rst),
    .i_wb_pipe_we   (pipe_we),
    .i_wb_pipe_rd   (pipe_rd),
    .i_wb_pipe_data (pipe_data),
    .i_wb_lu_valid  (lu_valid),
    .i_wb_lu_rd     (lu_rd),
    .i_wb_lu_data   (lu_data),
    .o_wb_lu_ready  (lu_ready),
    .i_wb_issue     (issue),
    .i_wb_issue_rd  (issue_rd),
    .o_wb_busy      (busy),
    .o_wb_rf_we     (rf_we),
    .o_wb_rf_a      (rf_a),
    .o_wb_rf_wd     (rf_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic wr_t mk(input logic [4:0] a, input logic [63:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    return w;
  endfunction

  // Record whether the bench presented an active pipe write at this edge.
  always @(posedge clk) pipe_prev <= pipe_we && (pipe_rd != 5'd0) && !rst;

  // Scoreboard monitor. A pipe write must appear on the next edge. Any other write must be the oldest pending LU result.
  always @(negedge clk) begin
    wr_t e;
    if (pipe_prev) begin
      check("pipe_rf_we", rf_we, 1);
      if (pipe_q.size() == 0) begin
        check("pipe_q_underflow", pipe_q.size(), 1);
      end else begin
        e = pipe_q.pop_front();
        check("pipe_rf_a", rf_a, e.a);
        check("pipe_rf_wd", rf_wd, e.d);
      end
    end else if (rf_we) begin
      if (lu_q.size() == 0) begin
        check("lu_unexpected_write", lu_q.size(), 1);
      end else begin
        e = lu_q.pop_front();
        check("lu_rf_a", rf_a, e.a);
        check("lu_rf_wd", rf_wd, e.d);
      end
    end
  end

  initial begin
    rst = 1'b1; pipe_we = 1'b0; pipe_rd = '0; pipe_data = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_data = '0; issue = 1'b0; issue_rd = '0;

    // Reset state
    tick(); tick();
    check("rst_rf_we", rf_we, 0);
    check("rst_rf_a", rf_a, 0);
    check("rst_rf_wd", rf_wd, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", lu_ready, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", lu_ready, 1);

    // Pipe only. Then a pipe write to x0 is dropped and the outputs hold.
    pipe_we = 1'b1; pipe_rd = 5'd5; pipe_data = 64'hA5;
    pipe_q.push_back(mk(5'd5, 64'hA5));
    tick();
    check("pipe5_we", rf_we, 1);
    check("pipe5_a", rf_a, 5);
    check("pipe5_wd", rf_wd, 64'hA5);
    pipe_rd = 5'd0; pipe_data = 64'hFF;
    tick();
    check("pipe_x0_we", rf_we, 0);
    check("pipe_x0_hold_a", rf_a, 5);
    check("pipe_x0_hold_wd", rf_wd, 64'hA5);
    pipe_we = 1'b0;

    // Issue x7, then an LU result for x7 with the pipe idle
    issue = 1'b1; issue_rd = 5'd7;
    tick();
    issue = 1'b0;
    check("busy7_set", busy, 32'h80);
    lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 64'h1234;
    lu_q.push_back(mk(5'd7, 64'h1234));
    #1;
    check("lu7_ready", lu_ready, 1);
    tick();
    lu_valid = 1'b0;
`ifdef RISCV_WB_BYPASS_EN
    check("lu7_byp_we", rf_we, 1);
    check("lu7_byp_a", rf_a, 7);
    check("lu7_byp_wd", rf_wd, 64'h1234);
    check("busy7_clr", busy, 0);
`else
    check("lu7_wait_we", rf_we, 0);
    check("busy7_still", busy, 32'h80);
    tick();
    check("lu7_we", rf_we, 1);
    check("lu7_a", rf_a, 7);
    check("lu7_wd", rf_wd, 64'h1234);
    check("busy7_clr", busy, 0);
`endif

    // Contention: four pipe writes while LU delivers x3 then x4
    issue = 1'b1; issue_rd = 5'd3;
    tick();
    issue_rd = 5'd4;
    tick();
    issue = 1'b0;
    check("busy34_set", busy, 32'h18);
    for (int i = 0; i < 4; i++) begin
      pipe_we = 1'b1; pipe_rd = 5'(10 + i); pipe_data = 64'(100 + i);
      pipe_q.push_back(mk(5'(10 + i), 64'(100 + i)));
      if (i == 0) begin
        lu_valid = 1'b1; lu_rd = 5'd3; lu_data = 64'h3333;
        lu_q.push_back(mk(5'd3, 64'h3333));
      end else if (i == 1) begin
        lu_rd = 5'd4; lu_data = 64'h4444;
        lu_q.push_back(mk(5'd4, 64'h4444));
      end else begin
        lu_valid = 1'b0;
      end
      tick();
      if (i == 0) check("ready_one_entry", lu_ready, 1);
      if (i == 1) check("ready_full", lu_ready, 0);
      if (i == 3) check("ready_full_held", lu_ready, 0);
    end
    pipe_we = 1'b0;
    tick();
    check("drain3_a", rf_a, 3);
    check("drain3_wd", rf_wd, 64'h3333);
    check("busy_after3", busy, 32'h10);
    tick();
    check("drain4_a", rf_a, 4);
    check("drain4_wd", rf_wd, 64'h4444);
    check("busy_after4", busy, 0);
    check("ready_drained", lu_ready, 1);

    // Same-edge issue and LU writeback of x9: the set wins
    issue = 1'b1; issue_rd = 5'd9;
    tick();
    issue = 1'b0;
    check("busy9_set", busy, 32'h200);
    lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 64'h9999;
    lu_q.push_back(mk(5'd9, 64'h9999));
`ifdef RISCV_WB_BYPASS_EN
    issue = 1'b1;
    tick();
    lu_valid = 1'b0; issue = 1'b0;
`else
    tick();
    lu_valid = 1'b0; issue = 1'b1;
    tick();
    issue = 1'b0;
`endif
    check("lu9_we", rf_we, 1);
    check("lu9_a", rf_a, 9);
    check("busy9_kept", busy, 32'h200);
    tick();
    check("busy9_stays", busy, 32'h200);
    check("idle_we", rf_we, 0);

    // LU result to x0 with the port idle: consumed, never written
    lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 64'hDEAD;
    #1;
    check("lu_x0_ready", lu_ready, 1);
    tick();
    lu_valid = 1'b0;
    check("lu_x0_no_we_1", rf_we, 0);
    tick();
    check("lu_x0_no_we_2", rf_we, 0);

    // Fill the FIFO behind pipe traffic. The x0 result must not take a slot.
    issue = 1'b1; issue_rd = 5'd12;
    tick();
    issue_rd = 5'd13;
    tick();
    issue = 1'b0;
    check("busy_pre_rst", busy, 32'h3200);
    for (int i = 0; i < 3; i++) begin
      pipe_we = 1'b1; pipe_rd = 5'(20 + i); pipe_data = 64'(200 + i);
      pipe_q.push_back(mk(5'(20 + i), 64'(200 + i)));
      lu_valid = 1'b1;
      lu_rd = (i == 0) ? 5'd0 : 5'(11 + i);
      lu_data = 64'(16'hC000 + i);
      if (i != 0) lu_q.push_back(mk(5'(11 + i), 64'(16'hC000 + i)));
      tick();
      if (i == 1) check("x0_not_counted", lu_ready, 1);
      if (i == 2) check("fifo_full_pre_rst", lu_ready, 0);
    end

    // Reset with the FIFO full and busy bits set
    pipe_we = 1'b0; lu_valid = 1'b0; rst = 1'b1;
    lu_q.delete();
    tick();
    check("rst2_rf_we", rf_we, 0);
    check("rst2_rf_a", rf_a, 0);
    check("rst2_busy", busy, 0);
    check("rst2_ready", lu_ready, 0);
    rst = 1'b0;
    #1;
    check("rst2_ready_after", lu_ready, 1);
    tick();
    check("rst2_no_drain_1", rf_we, 0);
    tick();
    check("rst2_no_drain_2", rf_we, 0);
    #5;
    check("pipe_q_empty", pipe_q.size(), 0);
    check("lu_q_empty", lu_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
